// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch queue: FSM encoding and counter sizing.
package fetch_pkg;

    typedef enum logic [1:0] {BOOT, RUN, HALTED} fetch_state_t;

    // Counters must hold the value DEPTH itself, hence the extra bit.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with flush; flush empties the queue and wins over push.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  W     = 32,
    parameter int  DEPTH = 4,
    localparam int CW    = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch front-end: sequential PC issue, credit-limited requests, redirect flush with stale-response discard.
// Define FETCH_BYPASS_EN to forward a response straight to decode when the queue is empty.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 4,
    parameter int PC_STEP  = 4,
    parameter int RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [DATA_W-1:0] dec_instr,
    output logic [ADDR_W-1:0] dec_pc,
    output logic              err_unexpected_rsp
);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] pc;
    } fetch_entry_t;

    fetch_state_t      state, state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [CW-1:0]     outstanding, outstanding_nxt, discard, count;
    logic [CW:0]       credits;
    logic              err, issue, req_hs, rsp_ok, rsp_keep, bypass, push, pop;
    fetch_entry_t      rsp_entry, head, out_entry;

    always_ff @(posedge clk) begin
        if (!reset) state <= BOOT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (halt)  state_nxt = HALTED;
            HALTED:  if (!halt) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    // Credits cover both queued entries and in-flight requests, so a push never finds the queue full.
    always_comb begin
        credits = {1'b0, count} + {1'b0, outstanding};
        issue   = 1'b0;
        if (state == RUN && credits < (CW+1)'(DEPTH)) issue = 1'b1;
    end

    assign req_hs          = imem_req_valid && imem_req_ready;
    assign rsp_ok          = imem_rsp_valid && (outstanding != '0);
    assign rsp_keep        = rsp_ok && (discard == '0) && !redirect_valid;
    assign outstanding_nxt = outstanding + CW'(req_hs) - CW'(rsp_ok);
    assign rsp_entry       = '{instr: imem_rsp_data, pc: rsp_pc};

`ifdef FETCH_BYPASS_EN
    assign bypass = rsp_ok && (discard == '0) && (count == '0);
`else
    assign bypass = 1'b0;
`endif

    assign push      = rsp_keep && !(bypass && dec_ready);
    assign pop       = (count != '0) && dec_ready;
    assign out_entry = bypass ? rsp_entry : head;

    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc    <= ADDR_W'(RESET_PC);
            rsp_pc      <= ADDR_W'(RESET_PC);
            outstanding <= '0;
            discard     <= '0;
            err         <= 1'b0;
        end else begin
            outstanding <= outstanding_nxt;
            if (imem_rsp_valid && outstanding == '0) err <= 1'b1;
            // Everything still in flight after this cycle belongs to the old stream.
            if (redirect_valid) begin
                fetch_pc <= redirect_pc;
                rsp_pc   <= redirect_pc;
                discard  <= outstanding_nxt;
            end else begin
                if (req_hs) fetch_pc <= fetch_pc + STEP;
                if (rsp_ok) begin
                    if (discard != '0) discard <= discard - CW'(1);
                    else               rsp_pc  <= rsp_pc + STEP;
                end
            end
        end
    end

    fetch_fifo #(
        .W     ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (rsp_entry),
        .pop       (pop),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count)
    );

    assign imem_req_valid     = reset && issue;
    assign imem_req_addr      = reset ? fetch_pc : '0;
    assign dec_valid          = reset && ((count != '0) || bypass);
    assign dec_instr          = reset ? out_entry.instr : '0;
    assign dec_pc             = reset ? out_entry.pc : '0;
    assign err_unexpected_rsp = reset && err;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized bench for instr_fetch_queue against a transaction-level model of the PC stream.
module tb_instr_fetch_queue;
    localparam int DEPTH = 4;

    logic        clk, reset;
    logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
    logic [15:0] imem_req_addr, imem_rsp_data;
    logic        redirect_valid, halt, dec_valid, dec_ready, err_unexpected_rsp;
    logic [15:0] redirect_pc, dec_instr, dec_pc;

    instr_fetch_queue #(
        .DATA_W(16), .ADDR_W(16), .DEPTH(DEPTH), .PC_STEP(4), .RESET_PC(0)
    ) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .dec_valid(dec_valid),
        .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .err_unexpected_rsp(err_unexpected_rsp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          nchk = 0, nerr = 0;
    int          ncall = 0, nreq = 0, ndec = 0, first_req = -1, first_dec = -1;
    logic [15:0] pend[$];
    logic [15:0] dec_log[$];
    logic [15:0] exp_fetch = 16'h0000, exp_dec = 16'h0000, last_req = 16'h0001;
    bit          halt_q = 1'b0, saw_wrap = 1'b0;

    // Memory contents: a fixed scramble of the address.
    function automatic logic [15:0] fdat(input logic [15:0] a);
        return (a ^ 16'h5A5A) + {a[7:0], a[15:8]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, settle, check against the model, advance past the edge.
    task automatic cycle(input bit rdy, input bit rsp, input bit drdy, input bit redir,
                         input logic [15:0] rpc, input bit hlt, input bit force_rsp);
        imem_req_ready = rdy;
        imem_rsp_valid = force_rsp || (rsp && pend.size() > 0);
        imem_rsp_data  = (pend.size() > 0) ? fdat(pend[0]) : 16'($urandom);
        dec_ready      = drdy;
        redirect_valid = redir;
        redirect_pc    = rpc;
        halt           = hlt;
        #1;
        ncall++;
        if (halt_q) chk("halt_noreq", imem_req_valid, 0);
        if (imem_rsp_valid && pend.size() > 0) void'(pend.pop_front());
        if (imem_req_valid && first_req < 0) first_req = ncall;
        if (imem_req_valid && imem_req_ready) begin
            chk("req_addr", imem_req_addr, exp_fetch);
            if (last_req == 16'hFFFC) begin
                chk("wrap", imem_req_addr, 0);
                saw_wrap = 1'b1;
            end
            last_req = imem_req_addr;
            pend.push_back(imem_req_addr);
            exp_fetch += 16'd4;
            nreq++;
            chk("credit", pend.size() <= DEPTH, 1);
        end
        if (dec_valid && first_dec < 0) first_dec = ncall;
        if (dec_valid && dec_ready) begin
            chk("dec_pc", dec_pc, exp_dec);
            chk("dec_instr", dec_instr, fdat(dec_pc));
            dec_log.push_back(dec_pc);
            exp_dec += 16'd4;
            ndec++;
        end
        if (redir) begin
            exp_fetch = rpc;
            exp_dec   = rpc;
            last_req  = 16'h0001;
        end
        halt_q = hlt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n0, d0, k;
        bit hr;
        reset = 1'b0; imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_data = '0;
        redirect_valid = 0; redirect_pc = '0; halt = 0; dec_ready = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_req_addr", imem_req_addr, 0);
        chk("rst_dec_valid", dec_valid, 0);
        chk("rst_dec_pc", dec_pc, 0);
        chk("rst_err", err_unexpected_rsp, 0);
        reset = 1'b1;

        // Startup latency, always-ready memory with 1-cycle response
        repeat (8) cycle(1, 1, 1, 0, 0, 0, 0);
        chk("first_req_cycle", first_req, 2);
`ifdef FETCH_BYPASS_EN
        chk("first_dec_cycle", first_dec, 3);
`else
        chk("first_dec_cycle", first_dec, 4);
`endif
        chk("first_dec_pc", dec_log.size() > 0 ? dec_log[0] : 16'hDEAD, 16'h0000);

        // Credit limit with decode stalled
        repeat (8) cycle(1, 1, 1, 0, 0, 1, 0);
        n0 = nreq;
        repeat (10) cycle(1, 1, 0, 0, 0, 0, 0);
        chk("fill_reqs", nreq - n0, DEPTH);
        chk("fill_stop", imem_req_valid, 0);
        cycle(1, 1, 1, 0, 0, 0, 0);
        repeat (5) cycle(1, 1, 0, 0, 0, 0, 0);
        chk("refill_one", nreq - n0, DEPTH + 1);

        // Redirect with two requests outstanding
        cycle(1, 1, 1, 1, 16'h0010, 1, 0);
        repeat (10) cycle(1, 1, 1, 0, 0, 1, 0);
        n0 = nreq;
        k = 0;
        while (nreq < n0 + 2 && k < 20) begin
            cycle(1, 0, 1, 0, 0, 0, 0);
            k++;
        end
        chk("two_outstanding", nreq - n0, 2);
        d0 = ndec;
        cycle(0, 0, 1, 1, 16'h0100, 0, 0);
        chk("flush_empty", dec_valid, 0);
        repeat (12) cycle(1, 1, 1, 0, 0, 0, 0);
        chk("redir_first", dec_log.size() > d0 ? dec_log[d0] : 16'hDEAD, 16'h0100);

        // Address wrap
        cycle(1, 1, 1, 1, 16'hFFF8, 1, 0);
        repeat (8) cycle(1, 1, 1, 0, 0, 1, 0);
        repeat (10) cycle(1, 1, 1, 0, 0, 0, 0);
        chk("wrap_seen", saw_wrap, 1);

        // Halt mid-stream then resume
        repeat (8) cycle(1, 1, 1, 0, 0, 1, 0);
        chk("halt_drained", pend.size(), 0);
        chk("halt_q_empty", dec_valid, 0);
        n0 = nreq;
        repeat (8) cycle(1, 1, 1, 0, 0, 0, 0);
        chk("resume_reqs", nreq > n0, 1);

        // Randomized traffic
        d0 = ndec;
        hr = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(99) < 5) hr = ~hr;
            cycle($urandom_range(99) < 75, $urandom_range(99) < 60, $urandom_range(99) < 70,
                  $urandom_range(99) < 3, 16'($urandom) & 16'hFFFC, hr, 0);
        end
        chk("rand_progress", ndec - d0 > 200, 1);

        // Unexpected response
        repeat (20) cycle(1, 1, 1, 0, 0, 1, 0);
        chk("drain_empty", pend.size(), 0);
        chk("err_clean", err_unexpected_rsp, 0);
        cycle(1, 0, 0, 0, 0, 1, 1);
        chk("err_set", err_unexpected_rsp, 1);
        chk("err_q_unchanged", dec_valid, 0);
        repeat (3) cycle(1, 0, 1, 0, 0, 1, 0);
        chk("err_sticky", err_unexpected_rsp, 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("err_cleared", err_unexpected_rsp, 0);
        chk("rst2_dec_valid", dec_valid, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
Parametrised fetch front-end for the next-generation pipelined core. It replaces the single PC register and stall-on-branch logic.
- Issues sequential instruction-memory requests through a valid/ready handshake.
- Buffers returned instructions in a DEPTH-entry FIFO and hands them to decode with valid/ready.
- On a redirect (taken branch or exception), flushes the queue and discards in-flight stale responses.
- Sits between instruction memory and the decode/register-fetch stage.

Parameters:
DATA_W, 16, instruction width in bits
ADDR_W, 16, PC / memory address width in bits
DEPTH, 4, queue entries; power of 2, minimum 2; also the cap on outstanding requests
PC_STEP, 4, byte increment between sequential fetches
RESET_PC, 0, first fetch address after reset

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-low reset
imem_req_valid  out  1  request to instruction memory
imem_req_ready  in  1  memory accepts the request this cycle
imem_req_addr  out  ADDR_W  fetch address
imem_rsp_valid  in  1  response beat; responses return in request order
imem_rsp_data  in  DATA_W  fetched instruction
redirect_valid  in  1  load a new PC and flush
redirect_pc  in  ADDR_W  redirect target
halt  in  1  stop issuing new requests
dec_valid  out  1  instruction available to decode
dec_ready  in  1  decode consumes this cycle
dec_instr  out  DATA_W  head instruction
dec_pc  out  ADDR_W  PC of the head instruction
err_unexpected_rsp  out  1  sticky; a response arrived with nothing outstanding

Behaviour:
- Reset (reset==0 at an edge):
  - fetch_pc=RESET_PC; queue empty; outstanding=0; discard=0; FSM=BOOT; err_unexpected_rsp=0.
  - All outputs are 0 while reset is low.
- FSM states:
  - BOOT: one cycle, no request issued, then go to RUN.
  - RUN: issue requests. RUN->HALTED when halt=1.
  - HALTED: no new requests. Outstanding responses still complete and the queue still drains. HALTED->RUN when halt=0.
  - redirect_valid is honoured in every state except during reset.
- Issue:
  - imem_req_valid = (state==RUN) && (count + outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - On req handshake: fetch_pc += PC_STEP (wraps mod 2^ADDR_W); outstanding += 1.
  - Each pending request stores its PC in a tag FIFO, or the PC is derived from the head; the implementation chooses.
  - imem_req_valid must not drop while imem_req_ready=0 unless a redirect or halt occurs.
- Response:
  - On imem_rsp_valid, outstanding -= 1.
  - If discard>0: discard -= 1 and the beat is dropped.
  - Otherwise the beat is pushed with its PC. Credit accounting guarantees the queue is never full on a push.
  - Response with outstanding==0: ignore it and set err_unexpected_rsp.
- Decode side:
  - dec_valid = (count>0); dec_instr and dec_pc come from the head.
  - Pop on dec_valid && dec_ready. Push and pop in the same cycle keep count unchanged.
- Redirect (same cycle, takes priority over everything):
  - fetch_pc <= redirect_pc; queue count <= 0.
  - discard <= outstanding after this cycle's issue and response updates, excluding a response beat consumed this cycle.
  - A request handshaken in the redirect cycle is stale and is counted into discard.
  - A dec handshake in the redirect cycle completes; decode must squash that instruction itself.
  - The next request uses redirect_pc no earlier than the following cycle.
- Back-to-back redirects: the last one wins; discard accumulates correctly.
- Latency: response to dec_valid is 1 cycle (registered queue write). Reset release to the first request is 2 cycles (BOOT).
- Counters: count and outstanding are clog2(DEPTH)+1 bits wide and never exceed DEPTH.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the queue is empty, discard==0 and imem_rsp_valid=1, the response drives dec_valid/dec_instr/dec_pc combinationally in the same cycle.
  - If dec_ready=1 that cycle, the beat is not written to the queue.
  - Response-to-decode latency becomes 0.
- Undefined: all responses pass through the queue; latency is 1 cycle.

Decomposition:
- Package fetch_pkg:
  - typedef fetch_state_t {BOOT, RUN, HALTED}.
  - Function clog2-based count width.
  - typedef fetch_entry_t {instr, pc} parametrised by width.
- One sub-module: fetch_fifo, a synchronous DEPTH-entry FIFO with push/pop/flush/count outputs.
- The top level holds the FSM, PC, credit counters and discard counters.

Test Plan:
- Reset release, memory always ready with 1-cycle response, dec_ready=1 -> requests at 0x0000, 0x0004, 0x0008…; first dec_valid with dec_pc=0x0000 three cycles after reset deasserts.
- dec_ready=0 with DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0; dec_ready=1 for one cycle -> one new request issued.
- Two requests outstanding (0x0010, 0x0014), then redirect to 0x0100 -> both responses dropped, queue empty; next request at 0x0100 and dec_pc=0x0100 is the first delivered.
- fetch_pc=0xFFFC with ADDR_W=16 -> next request address 0x0000.
- halt=1 mid-stream -> no new requests; outstanding responses still arrive and drain to decode; halt=0 -> resumes at the next sequential PC.
- imem_rsp_valid pulsed with outstanding=0 -> err_unexpected_rsp=1, remaining set until reset; queue unchanged.
